// File: rtl/dense_out_bank_if.sv
// Dense-output latch/read bundle between the PE-array controller (master)
// and the dense output bank (slave).
interface dense_out_bank_if #(
  parameter int N_PE     = 16,
  parameter int LOG_N_PE = 4,
  parameter int ACC_W    = 32,
  parameter int DW       = 16
);
  logic                    dense_latch;
  logic [LOG_N_PE:0]       lane_count;
  logic [N_PE*ACC_W-1:0]   pe_acc;
  logic                    latch_ready;
  logic                    dense_rd_en;
  logic [LOG_N_PE-1:0]     dense_rd_addr;
  logic [DW-1:0]           rd_data;
  logic                    rd_valid;
  logic                    bank_released;
  logic [1:0]              occupancy;
  logic                    err_overflow;
  logic                    err_underflow;
  logic                    err_addr;

  modport master (
    output dense_latch, lane_count, pe_acc, dense_rd_en, dense_rd_addr,
    input  latch_ready, rd_data, rd_valid, bank_released, occupancy,
           err_overflow, err_underflow, err_addr
  );

  modport slave (
    input  dense_latch, lane_count, pe_acc, dense_rd_en, dense_rd_addr,
    output latch_ready, rd_data, rd_valid, bank_released, occupancy,
           err_overflow, err_underflow, err_addr
  );
endinterface

// File: rtl/dense_out_bank.sv
// Ping/pong output bank: captures a rounded/saturated block of PE accumulators
// and serves lane reads with 1-cycle latency, freeing a bank after its last lane.
module dense_out_bank #(
  parameter int N_PE       = 16,
  parameter int LOG_N_PE   = 4,
  parameter int ACC_W      = 32,
  parameter int DW         = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  dense_out_bank_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_st_e;

  localparam logic signed [ACC_W:0]    RND     = (ACC_W+1)'(2**(FRAC_SHIFT-1));
  localparam logic signed [ACC_W:0]    SAT_MAX = (ACC_W+1)'(2**(DW-1) - 1);
  localparam logic signed [ACC_W:0]    SAT_MIN = (ACC_W+1)'(-(2**(DW-1)));
  localparam logic        [LOG_N_PE:0] CNT_MAX = (LOG_N_PE+1)'(N_PE);
  localparam logic        [LOG_N_PE:0] CNT_ONE = (LOG_N_PE+1)'(1);

  bank_st_e          st_q [2];
  bank_st_e          st_d [2];
  logic [DW-1:0]     mem_q [2][N_PE];
  logic [LOG_N_PE:0] cnt_q [2];
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [DW-1:0]     rd_data_q;
  logic              rd_valid_q;
  logic              released_q;
  logic              err_ovf_q;
  logic              err_unf_q;
  logic              err_addr_q;

  logic              latch_ready;
  logic [1:0]        occupancy;
  logic              accept;
  logic              rd_full;
  logic              rd_hit;
  logic              addr_bad;
  logic              release_rd;
  logic [LOG_N_PE:0] cnt_new;
  logic [LOG_N_PE:0] rd_addr_ext;

  // Round-half-up at ACC_W+1 bits so the +2^(FRAC_SHIFT-1) cannot wrap.
  function automatic logic [DW-1:0] sat_round(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shr;
    sum = $signed({acc[ACC_W-1], acc}) + RND;
    shr = sum >>> FRAC_SHIFT;
    if (shr > SAT_MAX)      return DW'(SAT_MAX);
    else if (shr < SAT_MIN) return DW'(SAT_MIN);
    else                    return shr[DW-1:0];
  endfunction

  always_comb begin
    cnt_new     = (bus.lane_count > CNT_MAX) ? CNT_MAX : bus.lane_count;
    rd_addr_ext = {1'b0, bus.dense_rd_addr};
    accept      = bus.dense_latch && latch_ready && (bus.lane_count != '0);
    rd_full     = (st_q[rd_bank_q] == FULL);
    rd_hit      = bus.dense_rd_en && rd_full;
    addr_bad    = (rd_addr_ext >= cnt_q[rd_bank_q]);
    release_rd  = rd_hit && (rd_addr_ext == (cnt_q[rd_bank_q] - CNT_ONE));
  end

  // Bank state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
    end else if (clear) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
    end
  end

  // Latch fills wr_bank and release drains rd_bank; both banks FULL means no
  // latch is accepted, so the two updates never hit the same bank.
  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    if (accept)     st_d[wr_bank_q] = FULL;
    if (release_rd) st_d[rd_bank_q] = EMPTY;
  end

  always_comb begin
    latch_ready = (st_q[0] == EMPTY) || (st_q[1] == EMPTY);
    occupancy   = 2'(st_q[0] == FULL) + 2'(st_q[1] == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
        for (int unsigned i = 0; i < N_PE; i++) mem_q[b][i] <= '0;
      end
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      released_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_addr_q <= 1'b0;
    end else if (clear) begin
      for (int unsigned b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
        for (int unsigned i = 0; i < N_PE; i++) mem_q[b][i] <= '0;
      end
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      released_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < N_PE; i++) begin
          mem_q[wr_bank_q][i] <= (i < 32'(cnt_new))
                                 ? sat_round(bus.pe_acc[i*ACC_W +: ACC_W]) : '0;
        end
        cnt_q[wr_bank_q] <= cnt_new;
        wr_bank_q        <= ~wr_bank_q;
      end
      if (release_rd) rd_bank_q <= ~rd_bank_q;
      if (rd_hit) rd_data_q <= addr_bad ? '0 : mem_q[rd_bank_q][bus.dense_rd_addr];
      rd_valid_q <= rd_hit;
      released_q <= release_rd;
      if (bus.dense_latch && !accept)       err_ovf_q  <= 1'b1;
      if (bus.dense_rd_en && !rd_full)      err_unf_q  <= 1'b1;
      if (rd_hit && addr_bad)               err_addr_q <= 1'b1;
    end
  end

  assign bus.latch_ready   = latch_ready;
  assign bus.occupancy     = occupancy;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.bank_released = released_q;
  assign bus.err_overflow  = err_ovf_q;
  assign bus.err_underflow = err_unf_q;
  assign bus.err_addr      = err_addr_q;

endmodule

// File: tb/tb_dense_out_bank.sv
// Directed bench for dense_out_bank: a vector table for rounding/tail/clamp
// reads plus hand-written sequences for reset, clear, ping/pong and async reset.
module tb_dense_out_bank;

  localparam int N_PE     = 16;
  localparam int LOG_N_PE = 4;
  localparam int ACC_W    = 32;
  localparam int DW       = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dense_out_bank_if #(.N_PE(N_PE), .LOG_N_PE(LOG_N_PE), .ACC_W(ACC_W), .DW(DW)) bus ();

  dense_out_bank #(.N_PE(N_PE), .LOG_N_PE(LOG_N_PE), .ACC_W(ACC_W), .DW(DW),
                   .FRAC_SHIFT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic        lat;
    logic [4:0]  lcnt;
    int          sel;
    logic        rd;
    logic [3:0]  addr;
    logic [15:0] e_dat;
    logic        e_vld;
    logic        e_rel;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [13];

  // sel 1: lane i = i<<8; sel 2: rounding/saturation corners then -(100*i)<<8;
  // sel 3: lane i = ((i+100)<<8) + 0x7F (just below the round-up point).
  function automatic logic [N_PE*ACC_W-1:0] mk_acc(input int sel);
    logic [N_PE*ACC_W-1:0] r;
    logic [31:0] v;
    r = '0;
    for (int i = 0; i < N_PE; i++) begin
      case (sel)
        1: v = i * 256;
        2: case (i)
             0: v = 32'h0000_0180;
             1: v = 32'h7FFF_FFFF;
             2: v = 32'h8000_0000;
             3: v = -384;
             default: v = -(i * 25600);
           endcase
        3: v = (i + 100) * 256 + 127;
        default: v = '0;
      endcase
      r[i*ACC_W +: ACC_W] = v;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic lat, input logic [4:0] lcnt, input int sel,
                        input logic rd, input logic [3:0] addr);
    bus.dense_latch   = lat;
    bus.lane_count    = lcnt;
    bus.pe_acc        = mk_acc(sel);
    bus.dense_rd_en   = rd;
    bus.dense_rd_addr = addr;
  endtask

  task automatic do_clear();
    set_in(1'b0, 5'd0, 0, 1'b0, 4'd0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'd16, 2, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[1]  = '{1'b0, 5'd0,  0, 1'b1, 4'd0,  16'h0002, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[2]  = '{1'b0, 5'd0,  0, 1'b1, 4'd1,  16'h7FFF, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[3]  = '{1'b0, 5'd0,  0, 1'b1, 4'd2,  16'h8000, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[4]  = '{1'b0, 5'd0,  0, 1'b1, 4'd3,  16'hFFFF, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 5'd3,  3, 1'b1, 4'd4,  16'hFE70, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[6]  = '{1'b0, 5'd0,  0, 1'b1, 4'd15, 16'hFA24, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 5'd0,  0, 1'b1, 4'd0,  16'h0064, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[8]  = '{1'b0, 5'd0,  0, 1'b1, 4'd2,  16'h0066, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[9]  = '{1'b0, 5'd0,  0, 1'b0, 4'd0,  16'h0066, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 5'd20, 1, 1'b0, 4'd0,  16'h0066, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 5'd0,  0, 1'b1, 4'd5,  16'h0005, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[12] = '{1'b0, 5'd0,  0, 1'b1, 4'd15, 16'h000F, 1'b1, 1'b1, 2'd0, 1'b1};

    set_in(1'b0, 5'd0, 0, 1'b0, 4'd0);
    rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst.rd_data",  32'(bus.rd_data), 32'h0);
    chk("rst.rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst.released", 32'(bus.bank_released), 32'h0);
    chk("rst.occ",      32'(bus.occupancy), 32'd0);
    chk("rst.ready",    32'(bus.latch_ready), 32'h1);
    chk("rst.errs",     32'({bus.err_overflow, bus.err_underflow, bus.err_addr}), 32'h0);
    #3 rst_n = 1'b1;

    // Read with nothing stored, then a zero-lane latch.
    set_in(1'b0, 5'd0, 0, 1'b1, 4'd0);
    cyc();
    chk("unf.rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("unf.err",      32'(bus.err_underflow), 32'h1);
    chk("unf.rd_data",  32'(bus.rd_data), 32'h0);
    set_in(1'b1, 5'd0, 1, 1'b0, 4'd0);
    cyc();
    chk("zero_cnt.err_ovf", 32'(bus.err_overflow), 32'h1);
    chk("zero_cnt.occ",     32'(bus.occupancy), 32'd0);

    // Clear wins over a latch and read in the same cycle.
    set_in(1'b1, 5'd16, 1, 1'b0, 4'd0);
    cyc();
    chk("pre_clr.occ", 32'(bus.occupancy), 32'd1);
    set_in(1'b1, 5'd16, 1, 1'b1, 4'd0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr.occ",      32'(bus.occupancy), 32'd0);
    chk("clr.ready",    32'(bus.latch_ready), 32'h1);
    chk("clr.rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("clr.errs",     32'({bus.err_overflow, bus.err_underflow, bus.err_addr}), 32'h0);
    set_in(1'b0, 5'd0, 0, 1'b0, 4'd0);
    cyc();
    chk("clr.hold_occ", 32'(bus.occupancy), 32'd0);

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].lat, tbl[i].lcnt, tbl[i].sel, tbl[i].rd, tbl[i].addr);
      cyc();
      chk($sformatf("tbl%0d.data", i),  32'(bus.rd_data), 32'(tbl[i].e_dat));
      chk($sformatf("tbl%0d.valid", i), 32'(bus.rd_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.rel", i),   32'(bus.bank_released), 32'(tbl[i].e_rel));
      chk($sformatf("tbl%0d.occ", i),   32'(bus.occupancy), 32'(tbl[i].e_occ));
      chk($sformatf("tbl%0d.ready", i), 32'(bus.latch_ready), 32'(tbl[i].e_rdy));
    end
    chk("tbl.errs", 32'({bus.err_overflow, bus.err_underflow, bus.err_addr}), 32'h0);
    do_clear();

    // Tail block: out-of-range address returns 0 and does not release.
    set_in(1'b1, 5'd3, 1, 1'b0, 4'd0);
    cyc();
    set_in(1'b0, 5'd0, 0, 1'b1, 4'd5);
    cyc();
    chk("tail.bad_data",  32'(bus.rd_data), 32'h0);
    chk("tail.bad_valid", 32'(bus.rd_valid), 32'h1);
    chk("tail.err_addr",  32'(bus.err_addr), 32'h1);
    chk("tail.bad_occ",   32'(bus.occupancy), 32'd1);
    set_in(1'b0, 5'd0, 0, 1'b1, 4'd2);
    cyc();
    chk("tail.last_data", 32'(bus.rd_data), 32'h2);
    chk("tail.rel",       32'(bus.bank_released), 32'h1);
    chk("tail.occ",       32'(bus.occupancy), 32'd0);
    do_clear();

    // Ping/pong: A and B stored, third latch rejected, B must survive.
    set_in(1'b1, 5'd16, 1, 1'b0, 4'd0);
    cyc();
    set_in(1'b1, 5'd16, 3, 1'b0, 4'd0);
    cyc();
    chk("pp.occ2",   32'(bus.occupancy), 32'd2);
    chk("pp.ready0", 32'(bus.latch_ready), 32'h0);
    set_in(1'b1, 5'd16, 2, 1'b1, 4'd0);
    cyc();
    chk("pp.rej_ovf",  32'(bus.err_overflow), 32'h1);
    chk("pp.rej_occ",  32'(bus.occupancy), 32'd2);
    chk("pp.a0",       32'(bus.rd_data), 32'h0);
    for (int i = 1; i < 16; i++) begin
      set_in(i == 15, 5'd16, 2, 1'b1, 4'(i));
      cyc();
      chk($sformatf("pp.a%0d", i), 32'(bus.rd_data), 32'(i));
      chk($sformatf("pp.a%0d.rel", i), 32'(bus.bank_released), 32'(i == 15));
    end
    chk("pp.no_bypass_occ", 32'(bus.occupancy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 5'd0, 0, 1'b1, 4'(i));
      cyc();
      chk($sformatf("pp.b%0d", i), 32'(bus.rd_data), 32'(i + 100));
      chk($sformatf("pp.b%0d.rel", i), 32'(bus.bank_released), 32'(i == 15));
    end
    chk("pp.final_occ", 32'(bus.occupancy), 32'd0);
    do_clear();

    // Async reset in the middle of a drain.
    set_in(1'b1, 5'd16, 1, 1'b0, 4'd0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 5'd0, 0, 1'b1, 4'(i));
      cyc();
      chk($sformatf("ar.d%0d", i), 32'(bus.rd_data), 32'(i));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("ar.rd_data",  32'(bus.rd_data), 32'h0);
    chk("ar.rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("ar.occ",      32'(bus.occupancy), 32'd0);
    chk("ar.ready",    32'(bus.latch_ready), 32'h1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk($sformatf("ar.rel%0d", i), 32'(bus.bank_released), 32'h0);
    end
    #3 rst_n = 1'b1;
    set_in(1'b0, 5'd0, 0, 1'b0, 4'd0);
    cyc();
    chk("ar.post_rel",   32'(bus.bank_released), 32'h0);
    chk("ar.post_occ",   32'(bus.occupancy), 32'd0);
    chk("ar.post_valid", 32'(bus.rd_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_out_bank.md
Name: dense_out_bank

Overview:
- Responder side of the dense-output latch/read interface, located in the PE-array datapath.
- On `dense_latch` it captures one output block of up to N_PE dense accumulator results, rounds and saturates each one, and parks the block in one of two ping/pong banks.
- It then serves the controller's sequential `dense_rd_addr` reads with 1-cycle latency and frees each bank once its last valid lane has been read.
- Double banking lets block k+1 be latched while block k is still draining to BUF.

Parameters:
N_PE, 16, number of PE lanes per output block
LOG_N_PE, 4, width of read address
ACC_W, 32, signed accumulator width per lane
DW, 16, signed output data width
FRAC_SHIFT, 8, arithmetic right shift applied at capture

Ports:
clk  in  1  clock; one clock
rst_n  in  1  reset is asynchronous and active-low
clear  in  1  synchronous flush of both banks and flags
dense_latch  in  1  capture request for pe_acc
lane_count  in  LOG_N_PE+1  valid lanes in this block (N_PE, or extra_ob for the tail block)
pe_acc  in  N_PE*ACC_W  lane i at bits [i*ACC_W +: ACC_W]
latch_ready  out  1  at least one bank EMPTY
dense_rd_en  in  1  read strobe
dense_rd_addr  in  LOG_N_PE  lane index within current read bank
rd_data  out  DW  registered read data
rd_valid  out  1  rd_data valid this cycle
bank_released  out  1  1-cycle pulse when a bank returns to EMPTY
occupancy  out  2  number of non-EMPTY banks (0..2)
err_overflow  out  1  sticky: latch while latch_ready=0, or lane_count==0
err_underflow  out  1  sticky: rd_en with no FULL bank
err_addr  out  1  sticky: rd_addr >= stored count

Behaviour:
- Reset (rst_n=0, async): both banks EMPTY, storage 0, wr_bank=rd_bank=0, rd_data=0, rd_valid=0, bank_released=0, occupancy=0, all err flags 0, latch_ready=1.
- clear=1: same end state as reset, applied on the clock edge; it overrides a latch or read in that same cycle.
- Bank state per bank: EMPTY -> FULL on accepted latch; FULL -> EMPTY on final read. There is no other state.
- latch_ready is combinational from the current bank states. Capture is accepted only when dense_latch=1, latch_ready=1 and lane_count!=0.
- Accepted capture, written into bank wr_bank at the clock edge:
  - lanes 0..cnt-1 each store sat_DW((acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT), where cnt = min(lane_count, N_PE).
  - The rounding add is done at ACC_W+1 bits. Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
  - lanes >= cnt store 0.
  - stored count = cnt; bank becomes FULL; wr_bank toggles.
- Rejected capture (dense_latch with latch_ready=0, or lane_count==0): no state change, err_overflow set.
- Read with rd_en=1 and bank rd_bank FULL:
  - next cycle: rd_valid=1, rd_data = bank[rd_bank][rd_addr].
  - if rd_addr >= count: rd_data=0, rd_valid=1, err_addr set.
- Release: when rd_en=1 and rd_addr == count-1 on a FULL bank, that bank goes EMPTY at the edge, rd_bank toggles, and bank_released pulses in the next cycle (aligned with the rd_valid of that final read).
- Reads need not be sequential; only the count-1 address triggers release.
- rd_en with bank rd_bank EMPTY: rd_valid=0 next cycle, rd_data holds its previous value, err_underflow set.
- rd_en=0: rd_valid=0 next cycle, rd_data holds.
- Simultaneous latch and release with both banks FULL: latch_ready=0 in that cycle, so the latch is rejected and err_overflow is set. There is no bypass.
- Simultaneous latch into the EMPTY bank and read/release of the other bank: both proceed independently.
- occupancy updates at the edge: +1 on accepted latch, -1 on release, net 0 when both happen in the same cycle.
- Latency: latch to first readable data = 1 cycle (a read issued the cycle after the latch is valid). Read to data = 1 cycle.
- Reset mid-drain discards all data; no release pulse is generated.

Test Plan:
- Basic: latch lane_count=16, lane i acc=i<<8; read addr 0..15 -> rd_data=i, rd_valid each cycle after rd_en, bank_released on the 16th rd_valid, occupancy 1->0.
- Rounding/saturation: acc lane0=0x00000180, lane1=0x7FFFFFFF, lane2=0x80000000, lane3=-0x180 -> rd_data 2, 0x7FFF, 0x8000, -1 (0xFFFF).
- Tail block: lane_count=3; read addr 0,1,2 -> release after addr 2; then read addr 5 on the next full bank (count 16) -> valid data; read addr 5 on a count=3 bank -> rd_data=0, err_addr=1.
- Ping/pong: latch A, latch B while A drains -> latch_ready=0, occupancy=2; third latch before A releases -> rejected, err_overflow=1, B data intact; drain A then B -> correct data in order.
- Underflow/clear: rd_en at reset -> rd_valid=0, err_underflow=1; latch, then clear -> occupancy=0, flags 0, latch_ready=1.
- Async reset mid-drain: assert rst_n=0 between clock edges at addr 7 -> outputs go to reset values immediately, no bank_released pulse.
